// File: rtl/av2_recon_frame_buffer_if.sv
// Reconstruction-write / reference-read bundle between the tile decoder and the
// ping-pong reconstruction frame buffer.
interface av2_recon_frame_buffer_if #(
    parameter int PIXEL_WIDTH = 10
);
    logic [127:0]           recon_data;
    logic [31:0]            recon_addr;
    logic                   recon_wr_en;
    logic                   frame_done;
    logic                   ref_read_en;
    logic [31:0]            ref_read_addr;
    logic [PIXEL_WIDTH-1:0] ref_pixel_data;
    logic                   ref_pixel_valid;
    logic                   ref_frame_valid;
    logic                   wr_bank;
    logic [15:0]            words_written;
    logic                   addr_err;

    modport master (
        output recon_data, recon_addr, recon_wr_en, frame_done,
        output ref_read_en, ref_read_addr,
        input  ref_pixel_data, ref_pixel_valid, ref_frame_valid,
        input  wr_bank, words_written, addr_err
    );

    modport slave (
        input  recon_data, recon_addr, recon_wr_en, frame_done,
        input  ref_read_en, ref_read_addr,
        output ref_pixel_data, ref_pixel_valid, ref_frame_valid,
        output wr_bank, words_written, addr_err
    );
endinterface

// File: rtl/av2_recon_frame_buffer.sv
// Ping-pong reconstruction frame buffer: captures 16-pixel words into the write
// bank, swaps on frame_done, and serves single pixels from the reference bank.
module av2_recon_frame_buffer #(
    parameter int MAX_WIDTH   = 64,
    parameter int MAX_HEIGHT  = 64,
    parameter int PIXEL_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    av2_recon_frame_buffer_if.slave    bus
);
    localparam int WORDS = MAX_WIDTH * MAX_HEIGHT / 16;
    localparam int AW    = $clog2(WORDS);

    // Both banks share one array; the bank index is the address MSB.
    logic [127:0] mem_q [0:2*WORDS-1];

    logic          wr_bank_q,       wr_bank_d;
    logic          ref_valid_q,     ref_valid_d;
    logic [15:0]   words_written_q, words_written_d;
    logic          addr_err_q,      addr_err_d;
    logic          rd_valid_q,      rd_valid_d;
    logic          rd_zero_q,       rd_zero_d;
    logic [3:0]    rd_lane_q,       rd_lane_d;
    logic [127:0]  rd_word_q;

    logic          wr_in_range_s;
    logic [AW-1:0] wr_word_s;
    logic [31:0]   rd_word_full_s;
    logic          rd_in_range_s;
    logic [AW-1:0] rd_word_s;
    logic [PIXEL_WIDTH-1:0] pixel_s;

    assign wr_in_range_s  = (bus.recon_addr < 32'(WORDS));
    assign wr_word_s      = bus.recon_addr[AW-1:0];
    assign rd_word_full_s = {4'd0, bus.ref_read_addr[31:4]};
    assign rd_in_range_s  = (rd_word_full_s < 32'(WORDS));
    assign rd_word_s      = rd_word_full_s[AW-1:0];

    // Bank RAM write port: synchronous, no reset on contents.
    always_ff @(posedge clk) begin
        if (rst_n && bus.recon_wr_en && wr_in_range_s) begin
            mem_q[{wr_bank_q, wr_word_s}] <= bus.recon_data;
        end
    end

    // Bank RAM registered read port, always from the current reference bank.
    always_ff @(posedge clk) begin
        if (bus.ref_read_en) begin
            rd_word_q <= mem_q[{~wr_bank_q, rd_word_s}];
        end
    end

    // Write bookkeeping, commit, and read-pipeline control next state.
    always_comb begin
        wr_bank_d       = wr_bank_q;
        ref_valid_d     = ref_valid_q;
        words_written_d = words_written_q;
        addr_err_d      = addr_err_q;
        rd_valid_d      = bus.ref_read_en;
        rd_zero_d       = rd_zero_q;
        rd_lane_d       = rd_lane_q;

        if (bus.recon_wr_en) begin
            if (!wr_in_range_s) begin
                addr_err_d = 1'b1;
            end else if (words_written_q != 16'hFFFF) begin
                words_written_d = words_written_q + 16'd1;
            end else begin
                words_written_d = words_written_q;
            end
        end else begin
            words_written_d = words_written_q;
        end

        // Commit wins over any same-cycle count/error update.
        if (bus.frame_done) begin
            wr_bank_d       = ~wr_bank_q;
            ref_valid_d     = 1'b1;
            words_written_d = 16'd0;
            addr_err_d      = 1'b0;
        end else begin
            wr_bank_d = wr_bank_q;
        end

        if (bus.ref_read_en) begin
            rd_zero_d = !ref_valid_q || !rd_in_range_s;
            rd_lane_d = bus.ref_read_addr[3:0];
        end else begin
            rd_zero_d = rd_zero_q;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q       <= 1'b0;
            ref_valid_q     <= 1'b0;
            words_written_q <= 16'd0;
            addr_err_q      <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_zero_q       <= 1'b1;
            rd_lane_q       <= 4'd0;
        end else begin
            wr_bank_q       <= wr_bank_d;
            ref_valid_q     <= ref_valid_d;
            words_written_q <= words_written_d;
            addr_err_q      <= addr_err_d;
            rd_valid_q      <= rd_valid_d;
            rd_zero_q       <= rd_zero_d;
            rd_lane_q       <= rd_lane_d;
        end
    end

    // Lane select on the registered RAM word; rd_zero_q forces 0 from reset on.
    always_comb begin
        pixel_s = '0;
        if (rd_zero_q) begin
            pixel_s = '0;
        end else begin
            pixel_s = {{(PIXEL_WIDTH-8){1'b0}}, rd_word_q[8*rd_lane_q +: 8]};
        end
    end

    assign bus.ref_pixel_data  = pixel_s;
    assign bus.ref_pixel_valid = rd_valid_q;
    assign bus.ref_frame_valid = ref_valid_q;
    assign bus.wr_bank         = wr_bank_q;
    assign bus.words_written   = words_written_q;
    assign bus.addr_err        = addr_err_q;
endmodule
